// File: rtl/multicycle_control_fsm_if.sv
// Memory request handshake between the multicycle sequencer
// and the shared instruction/data memory port.
interface multicycle_control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multicycle femtoRV32 datapath:
// steps FETCH/DECODE/EXEC/MEM/WB and drives datapath controls.
module multicycle_control_fsm #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_control_fsm_if.master bus,
  input  logic [6:0]       opcode,
  input  logic             branch_cond,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             bus_err,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  // Count only needs to reach TIMEOUT_CYCLES-1 before the limit cycle.
  localparam int WD_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIM =
    WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  state_t          cur;
  state_t          nxt;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;
  logic            retire;
  logic            timeout;
  logic            bad;

  logic is_r, is_i, is_ld, is_st, is_br;
  logic is_jal, is_jalr, is_lui, is_auipc;
  logic is_fence, is_sys, legal;

  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign is_br    = (opcode == OP_BR);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign is_fence = (opcode == OP_FENCE);
  assign is_sys   = (opcode == OP_SYS);
  assign legal    = is_r | is_i | is_ld | is_st | is_br
                  | is_jal | is_jalr | is_lui | is_auipc
                  | is_fence;

  assign wd_hit = WD_EN && (wd_cnt == WD_LIM);
  assign state  = cur;
  assign halted = (cur == S_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= S_RESET;
    else      cur <= nxt;
  end

  always_comb begin
    nxt          = cur;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_src_a    = 2'd0;
    alu_src_b    = 2'd0;
    alu_op       = 2'b00;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    retire       = 1'b0;
    timeout      = 1'b0;
    bad          = 1'b0;
    unique case (cur)
      S_RESET: nxt = S_FETCH;
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_a = 2'd1;
          alu_src_b = 2'd2;
          nxt       = S_DECODE;
        end else if (wd_hit) begin
          timeout = 1'b1;
          nxt     = S_HALT;
        end
      end
      S_DECODE: begin
        // Branch/JAL target is precomputed into alu_out here.
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        if (is_sys) begin
          nxt = S_HALT;
        end else if (!legal) begin
          bad = 1'b1;
          nxt = S_HALT;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        nxt = S_FETCH;
        unique case (1'b1)
          is_r: begin
            alu_op = 2'b10;
            nxt    = S_WB;
          end
          is_i: begin
            alu_src_b = 2'd1;
            alu_op    = 2'b10;
            nxt       = S_WB;
          end
          is_ld, is_st: begin
            alu_src_b = 2'd1;
            nxt       = S_MEM;
          end
          is_br: begin
            alu_op   = 2'b01;
            pc_write = branch_cond;
            pc_src   = branch_cond;
            retire   = 1'b1;
          end
          is_jal: begin
            reg_write = 1'b1;
            wb_sel    = 2'd2;
            pc_write  = 1'b1;
            pc_src    = 1'b1;
            retire    = 1'b1;
          end
          is_jalr: begin
            alu_src_b = 2'd1;
            pc_write  = 1'b1;
            reg_write = 1'b1;
            wb_sel    = 2'd2;
            retire    = 1'b1;
          end
          is_lui: begin
            alu_src_a = 2'd3;
            alu_src_b = 2'd1;
            nxt       = S_WB;
          end
          is_auipc: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
            nxt       = S_WB;
          end
          is_fence: retire = 1'b1;
          default: begin
            bad = 1'b1;
            nxt = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        bus.mem_req  = 1'b1;
        bus.addr_sel = 1'b1;
        bus.mem_we   = is_st;
        if (bus.mem_ready) begin
          if (is_st) begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (wd_hit) begin
          timeout = 1'b1;
          nxt     = S_HALT;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = is_ld ? 2'd1 : 2'd0;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_HALT;
    endcase
  end

  // Waiting states count stalls; any other cycle re-arms the watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt  <= '0;
      bus_err <= 1'b0;
      illegal <= 1'b0;
      instret <= '0;
    end else begin
      if ((cur == S_FETCH || cur == S_MEM) && !bus.mem_ready)
        wd_cnt <= wd_cnt + 1'b1;
      else
        wd_cnt <= '0;
      if (timeout) bus_err <= 1'b1;
      if (bad)     illegal <= 1'b1;
      if (retire)  instret <= instret + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench: per-instruction expected cycle sequences built
// from the sequencer's instruction timing table.
module tb_multicycle_control_fsm;
  localparam int TO = 4;
  localparam int CW = 4;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;
  localparam logic [6:0] JL_OP = 7'b1101111;
  localparam logic [6:0] JR_OP = 7'b1100111;
  localparam logic [6:0] LU_OP = 7'b0110111;
  localparam logic [6:0] AU_OP = 7'b0010111;
  localparam logic [6:0] FE_OP = 7'b0001111;
  localparam logic [6:0] SY_OP = 7'b1110011;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [6:0]    opcode = '0;
  logic          branch_cond = 1'b0;
  logic          ir_write, pc_write, pc_src;
  logic [1:0]    alu_src_a, alu_src_b, alu_op, wb_sel;
  logic          reg_write, halted, bus_err, illegal;
  logic [2:0]    state;
  logic [CW-1:0] instret;

  int checks = 0;
  int errors = 0;
  int retired = 0;

  multicycle_control_fsm_if bus();

  multicycle_control_fsm #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .opcode(opcode),
    .branch_cond(branch_cond),
    .ir_write(ir_write),
    .pc_write(pc_write),
    .pc_src(pc_src),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op(alu_op),
    .reg_write(reg_write),
    .wb_sel(wb_sel),
    .state(state),
    .halted(halted),
    .bus_err(bus_err),
    .illegal(illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(
    int st, bit rq, bit we, bit as, bit irw, bit pcw, bit pcs,
    int a, int b, int op, bit rw, int wb);
    logic [2:0] s3;
    logic [1:0] a2, b2, o2, w2;
    s3 = st[2:0]; a2 = a[1:0]; b2 = b[1:0];
    o2 = op[1:0]; w2 = wb[1:0];
    return {14'd0, s3, rq, we, as, irw, pcw, pcs,
            a2, b2, o2, rw, w2};
  endfunction

  function automatic logic [31:0] obs();
    return {14'd0, state, bus.mem_req, bus.mem_we,
            bus.addr_sel, ir_write, pc_write, pc_src,
            alu_src_a, alu_src_b, alu_op, reg_write, wb_sel};
  endfunction

  function automatic logic [31:0] flags();
    return {29'd0, halted, bus_err, illegal};
  endfunction

  task automatic cyc(input string tag, input logic [6:0] op,
                     input bit rdy, input bit bc,
                     input logic [31:0] exp);
    @(negedge clk);
    opcode = op;
    bus.mem_ready = rdy;
    branch_cond = bc;
    #1;
    chk(tag, obs(), exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    chk("rst_outputs", obs(), 32'd0);
    chk("rst_flags", flags(), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_state", obs(), pk(0,0,0,0,0,0,0,0,0,0,0,0));
    retired = 0;
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One instruction from FETCH to its retire; 1 if it ends in HALT.
  task automatic run_instr(input logic [6:0] op, input int fw,
                           input int mw, input bit bc,
                           output bit stopped);
    logic [31:0] fetch_w, ex_w, mem_w, wb_w;
    bit to_wb, to_mem, legal_op;
    stopped = 1'b0;
    fetch_w = pk(1,1,0,0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < fw; i++) begin
      cyc("fetch_wait", op, 1'b0, bc, fetch_w);
      if (i == 0) begin
        chk("instret", 32'(instret), 32'(retired % (1 << CW)));
        chk("flags_run", flags(), 32'd0);
      end
    end
    cyc("fetch", op, 1'b1, bc, pk(1,1,0,0,1,1,0,1,2,0,0,0));
    if (fw == 0)
      chk("instret", 32'(instret), 32'(retired % (1 << CW)));
    cyc("decode", op, rb(), bc, pk(2,0,0,0,0,0,0,2,1,0,0,0));
    legal_op = (op inside {R_OP, I_OP, LD_OP, ST_OP, BR_OP,
                           JL_OP, JR_OP, LU_OP, AU_OP, FE_OP});
    if (!legal_op) begin
      for (int k = 0; k < 3; k++) begin
        cyc("halt", op, 1'b1, bc, pk(6,0,0,0,0,0,0,0,0,0,0,0));
        chk("halt_flags", flags(), {29'd0, 1'b1, 1'b0, op != SY_OP});
      end
      stopped = 1'b1;
      return;
    end
    to_wb = 1'b0;
    to_mem = 1'b0;
    wb_w = pk(5,0,0,0,0,0,0,0,0,0,1,0);
    mem_w = pk(4,1,0,1,0,0,0,0,0,0,0,0);
    case (op)
      R_OP:  begin ex_w = pk(3,0,0,0,0,0,0,0,0,2,0,0); to_wb = 1; end
      I_OP:  begin ex_w = pk(3,0,0,0,0,0,0,0,1,2,0,0); to_wb = 1; end
      LU_OP: begin ex_w = pk(3,0,0,0,0,0,0,3,1,0,0,0); to_wb = 1; end
      AU_OP: begin ex_w = pk(3,0,0,0,0,0,0,2,1,0,0,0); to_wb = 1; end
      LD_OP: begin
        ex_w = pk(3,0,0,0,0,0,0,0,1,0,0,0);
        to_mem = 1;
        wb_w = pk(5,0,0,0,0,0,0,0,0,0,1,1);
      end
      ST_OP: begin
        ex_w = pk(3,0,0,0,0,0,0,0,1,0,0,0);
        to_mem = 1;
        mem_w = pk(4,1,1,1,0,0,0,0,0,0,0,0);
      end
      BR_OP: ex_w = pk(3,0,0,0,0,bc,bc,0,0,1,0,0);
      JL_OP: ex_w = pk(3,0,0,0,0,1,1,0,0,0,1,2);
      JR_OP: ex_w = pk(3,0,0,0,0,1,0,0,1,0,1,2);
      default: ex_w = pk(3,0,0,0,0,0,0,0,0,0,0,0);
    endcase
    cyc("exec", op, rb(), bc, ex_w);
    if (to_mem) begin
      for (int i = 0; i < mw; i++)
        cyc("mem_wait", op, 1'b0, bc, mem_w);
      cyc("mem", op, 1'b1, bc, mem_w);
      if (op == LD_OP) to_wb = 1;
    end
    if (to_wb) cyc("wb", op, rb(), bc, wb_w);
    retired++;
  endtask

  logic [6:0] ops [10];
  bit st;

  initial begin
    ops = '{R_OP, I_OP, LD_OP, ST_OP, BR_OP,
            JL_OP, JR_OP, LU_OP, AU_OP, FE_OP};
    bus.mem_ready = 1'b0;
    do_reset();

    // Directed sequences
    run_instr(R_OP, 0, 0, 0, st);
    run_instr(R_OP, 0, 0, 0, st);
    run_instr(LD_OP, 0, 3, 0, st);
    run_instr(BR_OP, 0, 0, 1, st);
    run_instr(BR_OP, 0, 0, 0, st);
    run_instr(JL_OP, 0, 0, 0, st);
    run_instr(ST_OP, 1, 2, 0, st);
    run_instr(R_OP, 3, 0, 0, st);

    // Randomized legal traffic; instret wraps at 2**CW
    for (int n = 0; n < 150; n++)
      run_instr(ops[$urandom_range(0, 9)],
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), rb(), st);
    cyc("fetch_end", R_OP, 1'b0, 1'b0, pk(1,1,0,0,0,0,0,0,0,0,0,0));
    chk("instret_end", 32'(instret), 32'(retired % (1 << CW)));

    // Illegal opcode halts, reset clears everything
    run_instr(7'b1111111, 0, 0, 0, st);
    do_reset();
    run_instr(SY_OP, 1, 0, 0, st);
    do_reset();

    // Reset mid-fetch abandons the request
    cyc("fetch_wait", R_OP, 1'b0, 1'b0, pk(1,1,0,0,0,0,0,0,0,0,0,0));
    cyc("fetch_wait", R_OP, 1'b0, 1'b0, pk(1,1,0,0,0,0,0,0,0,0,0,0));
    do_reset();

    // Fetch watchdog
    for (int i = 0; i < TO; i++)
      cyc("wd_fetch", R_OP, 1'b0, 1'b0, pk(1,1,0,0,0,0,0,0,0,0,0,0));
    cyc("wd_halt", R_OP, 1'b1, 1'b0, pk(6,0,0,0,0,0,0,0,0,0,0,0));
    chk("wd_flags", flags(), 32'b110);
    cyc("wd_stay", R_OP, 1'b1, 1'b0, pk(6,0,0,0,0,0,0,0,0,0,0,0));
    do_reset();
    run_instr(R_OP, TO - 1, 0, 0, st);
    run_instr(LD_OP, 0, TO - 1, 0, st);

    // Memory-phase watchdog
    cyc("fetch", LD_OP, 1'b1, 1'b0, pk(1,1,0,0,1,1,0,1,2,0,0,0));
    cyc("decode", LD_OP, 1'b0, 1'b0, pk(2,0,0,0,0,0,0,2,1,0,0,0));
    cyc("exec", LD_OP, 1'b0, 1'b0, pk(3,0,0,0,0,0,0,0,1,0,0,0));
    for (int i = 0; i < TO; i++)
      cyc("wd_mem", LD_OP, 1'b0, 1'b0, pk(4,1,0,1,0,0,0,0,0,0,0,0));
    cyc("wd_mhalt", LD_OP, 1'b1, 1'b0, pk(6,0,0,0,0,0,0,0,0,0,0,0));
    chk("wd_mflags", flags(), 32'b110);
    chk("wd_minstret", 32'(instret), 32'(retired % (1 << CW)));
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main sequencer for the multicycle femtoRV32 datapath. A single ALU and a single memory port are shared across fetch, address generation, branch-target and execute steps.
- Decodes the IR opcode and steps FETCH/DECODE/EXEC/MEM/WB.
- Drives ALUOp into the ALU control unit, plus ALU operand selects, PC/IR/register-file write enables and the memory request handshake.
- Also keeps a retired-instruction counter and a memory timeout watchdog.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for mem_ready in FETCH or MEM before the FSM faults to HALT. 0 disables the watchdog.
- CNT_W, 32: width of the instret counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0]
- branch_cond  in  1  comparator result for IR func3; valid in EXEC
- mem_ready  in  1  memory completes the request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe; only valid while mem_req=1
- addr_sel  out  1  memory address source: 0=PC, 1=alu_out register
- ir_write  out  1  latch IR and old_pc
- pc_write  out  1  PC update enable
- pc_src  out  1  PC source: 0=live ALU result, 1=alu_out register
- alu_src_a  out  2  operand A: 0=rs1, 1=PC, 2=old_pc, 3=zero
- alu_src_b  out  2  operand B: 0=rs2, 1=imm, 2=constant 4
- alu_op  out  2  to ALU control unit: 00=add, 01=sub, 10=func3/func7
- reg_write  out  1  register-file write enable
- wb_sel  out  2  write-back source: 0=alu_out, 1=mem data, 2=PC
- state  out  3  current state: RESET=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6
- halted  out  1  FSM is in HALT
- bus_err  out  1  sticky; watchdog expired
- illegal  out  1  sticky; undecodable opcode
- instret  out  CNT_W  count of retired instructions

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RESET; every output 0; instret=0; watchdog counter 0.
  - RESET is held for 1 cycle after release, then goes to FETCH.
  - Asserting reset mid-access drops mem_req immediately; any in-flight transaction is abandoned.
- Outputs not listed for a state are 0. alu_op=00 by default.
- FETCH:
  - Drives mem_req=1, addr_sel=0. Holds while mem_ready=0.
  - In the cycle with mem_ready=1: ir_write=1, pc_write=1, pc_src=0, A=PC, B=4 (so PC <= PC+4). Next state DECODE.
- DECODE:
  - A=old_pc, B=imm, add; the datapath latches the branch/JAL target into alu_out.
  - Opcode 1110011 (SYSTEM) -> HALT.
  - Opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111} -> HALT, illegal=1.
  - Otherwise -> EXEC.
- EXEC, by opcode:
  - R-type: A=rs1, B=rs2, alu_op=10 -> WB.
  - I-type ALU: A=rs1, B=imm, alu_op=10 -> WB.
  - LOAD/STORE: A=rs1, B=imm, add -> MEM.
  - BRANCH: A=rs1, B=rs2, alu_op=01. If branch_cond=1: pc_write=1, pc_src=1. Retire -> FETCH.
  - JAL: reg_write=1, wb_sel=2 (link = PC, already old_pc+4); pc_write=1, pc_src=1 on the same edge. Retire -> FETCH.
  - JALR: A=rs1, B=imm, add; pc_write=1, pc_src=0; reg_write=1, wb_sel=2 on the same edge. The datapath clears bit 0. Retire -> FETCH.
  - LUI: A=zero, B=imm -> WB.
  - AUIPC: A=old_pc, B=imm -> WB.
  - FENCE: no operation; retire -> FETCH.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=1 for STORE. Holds while mem_ready=0.
  - On mem_ready: STORE retires -> FETCH; LOAD -> WB.
- WB: reg_write=1; wb_sel=1 for LOAD, otherwise 0. Retire -> FETCH.
- HALT: halted=1; all enables 0; sticky until reset.
- Retire: instret increments by 1 on the edge leaving the retiring state, and wraps from all-ones to 0.
- Watchdog:
  - Counter clears on entry to FETCH or MEM and increments each cycle with mem_ready=0.
  - When the count reaches TIMEOUT_CYCLES: -> HALT, bus_err=1, mem_req deasserts next cycle.
  - If mem_ready arrives in the same cycle the count reaches the limit, mem_ready wins.
- Latency with zero-wait memory (mem_ready tied 1):
  - R/I/LUI/AUIPC: 4 cycles
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - BRANCH/JAL/JALR/FENCE: 3 cycles

Test Plan:
- Reset, mem_ready=1, opcode=0110011 held -> state sequence 0,1,2,3,5,1; alu_op=10 in EXEC; reg_write=1 only in WB; instret=1 after 5 cycles, 2 after 9.
- LOAD with mem_ready low for 3 cycles in MEM -> mem_req=1, addr_sel=1, mem_we=0 held 4 cycles; then WB with wb_sel=1; instret +1.
- BRANCH with branch_cond=1, then again with 0 -> EXEC alu_op=01; pc_write=1, pc_src=1 only in the taken case; both retire in 3 cycles.
- JAL -> EXEC asserts reg_write=1, wb_sel=2, pc_write=1, pc_src=1 together; returns to FETCH.
- opcode=1111111 -> DECODE to HALT; illegal=1, halted=1, mem_req=0 thereafter; rst=0 clears everything to 0.
- TIMEOUT_CYCLES=4, mem_ready=0 in FETCH -> HALT after 4 wait cycles, bus_err=1; a second run with mem_ready=1 on the 4th wait cycle must proceed to DECODE instead.
